// File: rtl/async_fifo_dc.sv
// Single-clock FIFO that keeps the wr*/rd* status views of the two-sided FIFO family.
// Register-array storage, registered read data, wrap-bit pointers for full/empty detection.
module async_fifo_dc #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 130,
  localparam int ADDR_W = $clog2(FIFO_DEPTH + 1) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrreq,
  input  logic [FIFO_WIDTH-1:0] wrdin,
  output logic                  wrfull,
  output logic                  wrempty,
  output logic [ADDR_W-1:0]     wrusedw,
  input  logic                  rdreq,
  output logic [FIFO_WIDTH-1:0] rddout,
  output logic                  rdfull,
  output logic                  rdempty,
  output logic [ADDR_W-1:0]     rdusedw
);

  localparam int CAP = 1 << ADDR_W;

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic [FIFO_WIDTH-1:0] mem [CAP];

  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] usedw;

  // Wrap bits differing with equal addresses means the writer is a full lap ahead.
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign usedw = wr_ptr[ADDR_W-1:0] - rd_ptr[ADDR_W-1:0];

  assign wr_en = wrreq && !full;
  assign rd_en = rdreq && !empty;

  // NOTE: the storage array has no reset; its contents are unreachable until written,
  // and leaving it out of reset lets it map onto plain register/RAM resources.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wrdin;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Read data holds between accepted reads, including across reads attempted while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rddout <= '0;
    end else if (rd_en) begin
      rddout <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  assign wrfull  = full;
  assign rdfull  = full;
  assign wrempty = empty;
  assign rdempty = empty;
  assign wrusedw = usedw;
  assign rdusedw = usedw;

endmodule

// File: tb/tb_async_fifo_dc.sv
// Self-checking bench for async_fifo_dc: a reference queue model drives expected data,
// flags and usedw for directed cases and a randomized run across several pointer wraps.
module tb_async_fifo_dc;

  localparam int W   = 8;
  localparam int AW  = 7;
  localparam int CAP = 128;

  logic          clk;
  logic          rst_n;
  logic          wrreq;
  logic [W-1:0]  wrdin;
  logic          wrfull;
  logic          wrempty;
  logic [AW-1:0] wrusedw;
  logic          rdreq;
  logic [W-1:0]  rddout;
  logic          rdfull;
  logic          rdempty;
  logic [AW-1:0] rdusedw;

  async_fifo_dc #(.FIFO_WIDTH(W), .FIFO_DEPTH(130)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrreq   (wrreq),
    .wrdin   (wrdin),
    .wrfull  (wrfull),
    .wrempty (wrempty),
    .wrusedw (wrusedw),
    .rdreq   (rdreq),
    .rddout  (rddout),
    .rdfull  (rdfull),
    .rdempty (rdempty),
    .rdusedw (rdusedw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int errors    = 0;

  // Reference model: stored words, occupancy and the last word handed out.
  logic [W-1:0] sb_q[$];
  int           model_count = 0;
  logic [W-1:0] model_dout  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [AW-1:0] u;
    u = AW'(model_count % CAP);
    return 32'({model_count == CAP, model_count == 0, u});
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".wrstat"}, 32'({wrfull, wrempty, wrusedw}), exp_status());
    check({tag, ".rdstat"}, 32'({rdfull, rdempty, rdusedw}), exp_status());
    check({tag, ".dout"},   32'(rddout), 32'(model_dout));
  endtask

  // One clock cycle with the given requests; the model decides acceptance from its own occupancy.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input string tag);
    logic wa, ra;
    wrreq = w;
    wrdin = d;
    rdreq = r;
    wa = w && (model_count < CAP);
    ra = r && (model_count > 0);
    @(posedge clk);
    #1;
    if (ra) begin
      model_dout = sb_q.pop_front();
      model_count--;
    end
    if (wa) begin
      sb_q.push_back(d);
      model_count++;
    end
    wrreq = 1'b0;
    rdreq = 1'b0;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    sb_q.delete();
    model_count = 0;
    model_dout  = '0;
  endtask

  initial begin
    logic w, r;
    int   pw, pr;

    rst_n = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    wrdin = '0;

    // Reset state.
    #30;
    check_outputs("reset");
    rst_n = 1'b1;

    // Five writes then five reads, data one cycle after each read request.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(8'h11 + i), 1'b0, "wr5");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, "rd5");
      check("rd5.value", 32'(rddout), 32'(8'h11 + i));
    end
    check("rd5.empty", 32'(rdempty), 32'd1);

    // Fill to capacity, attempt an overflow write, then simultaneous access while full.
    for (int i = 0; i < CAP; i++) cycle(1'b1, W'(i), 1'b0, "fill");
    check("fill.full",  32'(wrfull),  32'd1);
    check("fill.usedw", 32'(wrusedw), 32'd0);
    cycle(1'b1, 8'hAA, 1'b0, "overflow");
    cycle(1'b1, 8'hBB, 1'b1, "full_rw");
    check("full_rw.first", 32'(rddout), 32'd0);
    for (int i = 1; i < CAP; i++) begin
      cycle(1'b0, '0, 1'b1, "drain");
      check("drain.not_aa", 32'(rddout == 8'hAA), 32'd0);
    end
    check("drain.last", 32'(rddout), 32'(CAP - 1));

    // Reads while empty leave data and flags alone; simultaneous access while empty writes only.
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, "rd_empty");
    cycle(1'b1, 8'h5A, 1'b1, "empty_rw");
    check("empty_rw.hold", 32'(rddout), 32'(CAP - 1));
    cycle(1'b0, '0, 1'b1, "empty_rw.rd");
    check("empty_rw.data", 32'(rddout), 32'h5A);

    // Steady-state streaming with three words held.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'h30 + i), 1'b0, "pre3");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, W'(8'h40 + i), 1'b1, "stream");
      check("stream.usedw", 32'(rdusedw), 32'd3);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "stream.drain");

    // Randomized traffic in phases that alternate fill-heavy and drain-heavy mixes.
    for (int p = 0; p < 5; p++) begin
      pw = (p % 2 == 0) ? 85 : 30;
      pr = (p % 2 == 0) ? 35 : 80;
      for (int i = 0; i < 500; i++) begin
        w = ($urandom_range(0, 99) < pw) && (model_count < CAP);
        r = ($urandom_range(0, 99) < pr) && (model_count > 0);
        cycle(w, W'($urandom), r, "rand");
      end
    end

    // Asynchronous reset mid-operation takes effect without a clock edge.
    for (int i = 0; i < 6; i++) cycle(1'b1, W'(8'hC0 + i), 1'b0, "pre_rst");
    cycle(1'b0, '0, 1'b1, "pre_rst.rd");
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs("async_rst");
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, "post_rst.wr");
    cycle(1'b0, '0, 1'b1, "post_rst.rd");
    check("post_rst.data", 32'(rddout), 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
